// File: rtl/hci_mem_demux_static.sv
// Static 1-to-NB_CHAN demultiplexer for an hci_mem initiator port.
// Responses are steered back from the port that holds the outstanding transactions.
module hci_mem_demux_static #(
  parameter int NB_CHAN         = 2,
  parameter int DW              = 32,
  parameter int AW              = 32,
  parameter int BW              = 8,
  parameter int WW              = 32,
  parameter int IW              = 10,
  parameter int UW              = 1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SW             = $clog2(NB_CHAN),
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
  localparam int BEW            = DW / BW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [SW-1:0]                sel_i,
  // initiator side
  input  logic                         in_req,
  output logic                         in_gnt,
  input  logic [AW-1:0]                in_add,
  input  logic                         in_wen,
  input  logic [DW-1:0]                in_data,
  input  logic [BEW-1:0]               in_be,
  input  logic [IW-1:0]                in_id,
  input  logic [UW-1:0]                in_user,
  output logic                         in_r_valid,
  output logic [DW-1:0]                in_r_data,
  output logic [IW-1:0]                in_r_id,
  output logic [UW-1:0]                in_r_user,
  // target side
  output logic [NB_CHAN-1:0]           out_req,
  input  logic [NB_CHAN-1:0]           out_gnt,
  output logic [NB_CHAN-1:0][AW-1:0]   out_add,
  output logic [NB_CHAN-1:0]           out_wen,
  output logic [NB_CHAN-1:0][DW-1:0]   out_data,
  output logic [NB_CHAN-1:0][BEW-1:0]  out_be,
  output logic [NB_CHAN-1:0][IW-1:0]   out_id,
  output logic [NB_CHAN-1:0][UW-1:0]   out_user,
  input  logic [NB_CHAN-1:0]           out_r_valid,
  input  logic [NB_CHAN-1:0][DW-1:0]   out_r_data,
  input  logic [NB_CHAN-1:0][IW-1:0]   out_r_id,
  input  logic [NB_CHAN-1:0][UW-1:0]   out_r_user,
  output logic                         busy_o,
  output logic                         err_o
);

  if (NB_CHAN < 2 || MAX_OUTSTANDING < 1 || WW < 1 || (DW % BW) != 0) begin : g_param_check
    $error("hci_mem_demux_static: illegal parameterisation");
  end

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [SW-1:0] lock_sel_reg, lock_sel_next;
  logic          err_reg, err_next;

  logic          sel_gnt;
  logic          lock_r_valid;
  logic [DW-1:0] lock_r_data;
  logic [IW-1:0] lock_r_id;
  logic [UW-1:0] lock_r_user;
  logic          spurious;
  logic          rsp;
  logic          stall;
  logic          grant;

  // Select the grant of the requested port and the response of the locked port;
  // any response arriving elsewhere is spurious.
  always_comb begin
    sel_gnt      = 1'b0;
    lock_r_valid = 1'b0;
    lock_r_data  = '0;
    lock_r_id    = '0;
    lock_r_user  = '0;
    spurious     = 1'b0;
    for (int k = 0; k < NB_CHAN; k++) begin
      if (sel_i == SW'(k)) begin
        sel_gnt = out_gnt[k];
      end
      if (lock_sel_reg == SW'(k)) begin
        lock_r_valid = out_r_valid[k];
        lock_r_data  = out_r_data[k];
        lock_r_id    = out_r_id[k];
        lock_r_user  = out_r_user[k];
      end else if (out_r_valid[k]) begin
        spurious = 1'b1;
      end
    end
    if (lock_r_valid && cnt_reg == '0) begin
      spurious = 1'b1;
    end
  end

  assign rsp   = lock_r_valid && (cnt_reg != '0);
  assign stall = ((cnt_reg != '0) && (sel_i != lock_sel_reg)) ||
                 ((cnt_reg == CW'(MAX_OUTSTANDING)) && !rsp);
  assign in_gnt = sel_gnt && !stall;
  assign grant  = in_req && in_gnt;

  for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_port
    assign out_req[gi]  = in_req && !stall && (sel_i == SW'(gi));
    assign out_add[gi]  = in_add;
    assign out_wen[gi]  = in_wen;
    assign out_data[gi] = in_data;
    assign out_be[gi]   = in_be;
    assign out_id[gi]   = in_id;
    assign out_user[gi] = in_user;
  end

  assign in_r_valid = rsp;
  assign in_r_data  = lock_r_data;
  assign in_r_id    = lock_r_id;
  assign in_r_user  = lock_r_user;

  // clear_i overrides any grant/response bookkeeping in the same cycle.
  always_comb begin
    cnt_next      = cnt_reg;
    lock_sel_next = lock_sel_reg;
    err_next      = err_reg || spurious;
    if (grant) begin
      lock_sel_next = sel_i;
    end
    if (grant && !rsp) begin
      cnt_next = cnt_reg + CW'(1);
    end else if (rsp && !grant) begin
      cnt_next = cnt_reg - CW'(1);
    end
    if (clear_i) begin
      cnt_next      = '0;
      lock_sel_next = '0;
      err_next      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      lock_sel_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      lock_sel_reg <= lock_sel_next;
      err_reg      <= err_next;
    end
  end

  assign busy_o = (cnt_reg != '0);
  assign err_o  = err_reg;

endmodule

// File: tb/tb_hci_mem_demux_static.sv
// Directed bench for hci_mem_demux_static: 2 ports, MAX_OUTSTANDING = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
module tb_hci_mem_demux_static;

  localparam int NB_CHAN = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = 8;
  localparam int IW = 10;
  localparam int UW = 1;
  localparam int MAXO = 4;

  logic clk_i = 1'b0;
  logic rst_ni, clear_i;
  logic sel_i;
  logic in_req, in_gnt, in_wen, in_r_valid;
  logic [AW-1:0] in_add;
  logic [DW-1:0] in_data, in_r_data;
  logic [DW/BW-1:0] in_be;
  logic [IW-1:0] in_id, in_r_id;
  logic [UW-1:0] in_user, in_r_user;
  logic [NB_CHAN-1:0] out_req, out_gnt, out_wen, out_r_valid;
  logic [NB_CHAN-1:0][AW-1:0] out_add;
  logic [NB_CHAN-1:0][DW-1:0] out_data, out_r_data;
  logic [NB_CHAN-1:0][DW/BW-1:0] out_be;
  logic [NB_CHAN-1:0][IW-1:0] out_id, out_r_id;
  logic [NB_CHAN-1:0][UW-1:0] out_user, out_r_user;
  logic busy_o, err_o;

  int n_checks = 0;
  int n_fail = 0;
  int n_grant;

  always #5 clk_i = ~clk_i;

  hci_mem_demux_static #(
    .NB_CHAN(NB_CHAN), .DW(DW), .AW(AW), .BW(BW), .WW(32), .IW(IW), .UW(UW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .sel_i(sel_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_data(in_data), .in_be(in_be), .in_id(in_id), .in_user(in_user),
    .in_r_valid(in_r_valid), .in_r_data(in_r_data), .in_r_id(in_r_id),
    .in_r_user(in_r_user),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
    .out_data(out_data), .out_be(out_be), .out_id(out_id), .out_user(out_user),
    .out_r_valid(out_r_valid), .out_r_data(out_r_data), .out_r_id(out_r_id),
    .out_r_user(out_r_user),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; sel_i = 1'b0;
    in_req = 1'b0; in_add = '0; in_wen = 1'b1; in_data = '0; in_be = '1;
    in_id = '0; in_user = '0;
    out_gnt = '0; out_r_valid = '0; out_r_data = '0; out_r_id = '0; out_r_user = '0;
    #3;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_checks++; if (dut.cnt_reg !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_reg); end
    n_checks++; if (out_req !== 2'b00) begin n_fail++; $display("FAIL reset_out_req: got %b want 00", out_req); end
    n_checks++; if (in_r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b want 0", in_r_valid); end
    cyc(); cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_data;
    sel_i = 1'b0; out_gnt = 2'b11; in_wen = 1'b1;
    n_grant = 0;
    // First request: no response yet.
    in_req = 1'b1; in_add = 32'h100; in_id = 10'h15;
    #1;
    n_checks++; if (out_req !== 2'b01) begin n_fail++; $display("FAIL b2b_out_req: got %b want 01", out_req); end
    n_checks++; if (out_add[1] !== 32'h100) begin n_fail++; $display("FAIL b2b_bcast_add: got %h want 00000100", out_add[1]); end
    n_checks++; if (out_id[1] !== 10'h15) begin n_fail++; $display("FAIL b2b_bcast_id: got %h want 015", out_id[1]); end
    if (in_gnt === 1'b1) n_grant++;
    cyc();
    for (int i = 0; i < 3; i++) begin
      exp_data = 32'hA0 + 32'(i);
      in_req = (i < 2);
      in_add = 32'h104 + 32'(4 * i);
      out_r_valid = 2'b01;
      out_r_data[0] = exp_data;
      out_r_data[1] = 32'hDEAD;
      out_r_id[0] = 10'h15;
      #1;
      if (in_req && in_gnt === 1'b1) n_grant++;
      n_checks++; if (in_r_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_r_valid[%0d]: got %b want 1", i, in_r_valid); end
      n_checks++; if (in_r_data !== exp_data) begin n_fail++; $display("FAIL b2b_r_data[%0d]: got %h want %h", i, in_r_data, exp_data); end
      n_checks++; if (dut.cnt_reg !== 3'd1) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want 1", i, dut.cnt_reg); end
      $display("b2b rsp %0d data %h", i, in_r_data);
      cyc();
    end
    out_r_valid = '0;
    #1;
    n_checks++; if (in_r_id !== 10'h15) begin n_fail++; $display("FAIL b2b_r_id: got %h want 015", in_r_id); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_drop: got %b want 0", busy_o); end
    n_checks++; if (n_grant !== 3) begin n_fail++; $display("FAIL b2b_grants: got %0d want 3", n_grant); end
    cyc();
  endtask

  task automatic test_full();
    sel_i = 1'b1; out_gnt = 2'b11; in_req = 1'b1; out_r_valid = '0;
    n_grant = 0;
    for (int i = 0; i < 4; i++) begin
      in_add = 32'h200 + 32'(i);
      #1;
      n_checks++; if (in_gnt !== 1'b1 || out_req !== 2'b10) begin n_fail++; $display("FAIL full_fill[%0d]: gnt %b req %b want 1 10", i, in_gnt, out_req); end
      if (in_gnt === 1'b1) n_grant++;
      cyc();
    end
    n_checks++; if (dut.cnt_reg !== 3'd4) begin n_fail++; $display("FAIL full_cnt_max: got %0d want 4", dut.cnt_reg); end
    for (int i = 0; i < 9; i++) begin
      #1;
      n_checks++; if (in_gnt !== 1'b0 || out_req !== 2'b00) begin n_fail++; $display("FAIL full_stall[%0d]: gnt %b req %b want 0 00", i, in_gnt, out_req); end
      if (in_gnt === 1'b1) n_grant++;
      cyc();
    end
    out_r_valid = 2'b10; out_r_data[1] = 32'hD0;
    #1;
    n_checks++; if (in_gnt !== 1'b1) begin n_fail++; $display("FAIL full_gnt_on_rsp: got %b want 1", in_gnt); end
    n_checks++; if (in_r_data !== 32'hD0) begin n_fail++; $display("FAIL full_r_data: got %h want 000000d0", in_r_data); end
    if (in_gnt === 1'b1) n_grant++;
    cyc();
    n_checks++; if (dut.cnt_reg !== 3'd4) begin n_fail++; $display("FAIL full_cnt_hold: got %0d want 4", dut.cnt_reg); end
    n_checks++; if (n_grant !== 5) begin n_fail++; $display("FAIL full_grants: got %0d want 5", n_grant); end
    in_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_r_data[1] = 32'hD1 + 32'(i);
      cyc();
    end
    out_r_valid = '0;
    #1;
    n_checks++; if (dut.cnt_reg !== 3'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL full_drain: cnt %0d err %b want 0 0", dut.cnt_reg, err_o); end
    cyc();
  endtask

  task automatic test_switch();
    sel_i = 1'b0; out_gnt = 2'b11; in_req = 1'b1; out_r_valid = '0;
    cyc(); cyc();
    sel_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (in_gnt !== 1'b0 || out_req !== 2'b00) begin n_fail++; $display("FAIL sw_stall[%0d]: gnt %b req %b want 0 00", i, in_gnt, out_req); end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      out_r_valid = 2'b01; out_r_data[0] = 32'hB0 + 32'(i); out_r_data[1] = 32'hBAD;
      #1;
      n_checks++; if (in_r_valid !== 1'b1 || in_r_data !== 32'hB0 + 32'(i)) begin n_fail++; $display("FAIL sw_p0_rsp[%0d]: valid %b data %h want 1 %h", i, in_r_valid, in_r_data, 32'hB0 + 32'(i)); end
      n_checks++; if (in_gnt !== 1'b0 || out_req[1] !== 1'b0) begin n_fail++; $display("FAIL sw_drain_stall[%0d]: gnt %b req1 %b want 0 0", i, in_gnt, out_req[1]); end
      $display("switch rsp port0 data %h", in_r_data);
      cyc();
    end
    out_r_valid = '0;
    #1;
    n_checks++; if (in_gnt !== 1'b1 || out_req !== 2'b10) begin n_fail++; $display("FAIL sw_p1_gnt: gnt %b req %b want 1 10", in_gnt, out_req); end
    cyc();
    in_req = 1'b0; out_r_valid = 2'b10; out_r_data[1] = 32'hC0;
    #1;
    n_checks++; if (in_r_valid !== 1'b1 || in_r_data !== 32'hC0) begin n_fail++; $display("FAIL sw_p1_rsp: valid %b data %h want 1 000000c0", in_r_valid, in_r_data); end
    $display("switch rsp port1 data %h", in_r_data);
    cyc();
    out_r_valid = '0;
    #1;
    n_checks++; if (dut.cnt_reg !== 3'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL sw_end: cnt %0d err %b want 0 0", dut.cnt_reg, err_o); end
    cyc();
  endtask

  task automatic test_spurious();
    sel_i = 1'b0; out_gnt = 2'b11; in_req = 1'b1;
    cyc(); cyc();
    in_req = 1'b0; out_r_valid = 2'b10; out_r_data[1] = 32'hEE;
    #1;
    n_checks++; if (in_r_valid !== 1'b0) begin n_fail++; $display("FAIL spur_r_valid: got %b want 0", in_r_valid); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL spur_err_early: got %b want 0", err_o); end
    cyc();
    out_r_valid = '0;
    #1;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL spur_err: got %b want 1", err_o); end
    n_checks++; if (dut.cnt_reg !== 3'd2) begin n_fail++; $display("FAIL spur_cnt: got %0d want 2", dut.cnt_reg); end
  endtask

  task automatic test_async_reset();
    in_req = 1'b1;
    cyc();
    in_req = 1'b0;
    #1;
    n_checks++; if (dut.cnt_reg !== 3'd3 || err_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: cnt %0d err %b want 3 1", dut.cnt_reg, err_o); end
    #1;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (dut.cnt_reg !== 3'd0 || busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL arst_async: cnt %0d busy %b err %b want 0 0 0", dut.cnt_reg, busy_o, err_o); end
    cyc();
    rst_ni = 1'b1;
    out_r_valid = 2'b01; out_r_data[0] = 32'h5A;
    #1;
    n_checks++; if (in_r_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale_valid: got %b want 0", in_r_valid); end
    cyc();
    out_r_valid = '0;
    #1;
    n_checks++; if (err_o !== 1'b1 || dut.cnt_reg !== 3'd0) begin n_fail++; $display("FAIL arst_stale_err: err %b cnt %0d want 1 0", err_o, dut.cnt_reg); end
    cyc();
  endtask

  task automatic test_clear();
    sel_i = 1'b0; out_gnt = 2'b11; in_req = 1'b1;
    cyc();
    clear_i = 1'b1;
    #1;
    n_checks++; if (in_gnt !== 1'b1) begin n_fail++; $display("FAIL clr_gnt: got %b want 1", in_gnt); end
    cyc();
    clear_i = 1'b0; in_req = 1'b0;
    #1;
    n_checks++; if (dut.cnt_reg !== 3'd0 || busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL clr_state: cnt %0d busy %b err %b want 0 0 0", dut.cnt_reg, busy_o, err_o); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_switch();
    test_spurious();
    test_async_reset();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hci_mem_demux_static.md
Name: hci_mem_demux_static

Overview:
- Routes one hci_mem initiator port to one of NB_CHAN memory-side target ports, chosen by a quasi-static select. This is the 1-to-N counterpart of the N-to-1 static mux.
- Tracks in-flight transactions so responses always return from the port that granted them, even if sel_i moves while transactions are outstanding.
- Used where an accelerator streamer must alternate between memory regions (e.g. TCDM banks vs. local buffer) without a dynamic interconnect.

Parameters:
- NB_CHAN, 2, number of target ports (>=2).
- DW, hci_package::DEFAULT_DW, data width.
- AW, hci_package::DEFAULT_AW, address width.
- BW, hci_package::DEFAULT_BW, bits per byte-enable lane; be width = DW/BW.
- WW, hci_package::DEFAULT_WW, word width, passed through.
- IW, 10, id width.
- UW, hci_package::DEFAULT_UW, user width.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (>=1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset. Asynchronous, active-low.
- clear_i  input  1  synchronous clear of tracking state.
- sel_i  input  $clog2(NB_CHAN)  target port selected for new requests.
- in  hci_mem_intf.slave  -  initiator-side port.
- out  hci_mem_intf.master [NB_CHAN-1:0]  target-side ports.
- busy_o  output  1  high when outstanding count is non-zero.
- err_o  output  1  sticky flag: an unexpected response was seen.

Behaviour:
- State: cnt (width $clog2(MAX_OUTSTANDING+1)), lock_sel (width of sel_i), err. Reset and clear_i set all three to 0.
- Outputs: busy_o = (cnt != 0); err_o = err.
- Request path, combinational:
  - stall = (cnt != 0 && sel_i != lock_sel) || (cnt == MAX_OUTSTANDING && !rsp).
  - rsp = out[lock_sel].r_valid && cnt != 0.
  - out[sel_i].req = in.req && !stall. All other out[k].req = 0.
  - add, wen, data, be, id and user are broadcast to every out[k]. Only req is gated.
  - in.gnt = out[sel_i].gnt && !stall.
- Grant event: g = in.req && in.gnt. On g, lock_sel <= sel_i; it is stable whenever cnt > 0.
- Response path, combinational:
  - in.r_valid = rsp.
  - in.r_data, in.r_id and in.r_user come from out[lock_sel].
- Counter update:
  - g && !rsp: cnt+1.
  - rsp && !g: cnt-1.
  - g && rsp: cnt unchanged.
  - cnt never exceeds MAX_OUTSTANDING and never underflows.
- Protocol: every granted transaction (read or write) yields exactly one r_valid, in order, at least one cycle after its grant. A response in the same cycle as its own grant is not supported.
- Ordering: all outstanding transactions target a single port. A switch of sel_i while cnt > 0 stalls (gnt = 0, no req forwarded) until cnt drains to 0. The new port is then granted in the following cycles.
- Full: when cnt == MAX_OUTSTANDING, a new grant is allowed only in the same cycle as a response.
- Error conditions set err sticky:
  - any out[k].r_valid with k != lock_sel;
  - any out[k].r_valid while cnt == 0.
  - Such responses are dropped; cnt is not changed.
- clear_i has priority over the grant and response updates of the same cycle. Responses still in flight after a clear are flagged as errors.
- Reset asserted mid-transaction: all state returns to 0 immediately. Late responses after reset set err.
- in.req held high while stalled must not be granted.

Test Plan:
- sel_i=0, 3 back-to-back reads with out[0] gnt=1 and r_valid 1 cycle later -> 3 grants on consecutive cycles; in.r_data matches out[0].r_data each cycle; cnt peaks at 1; busy_o drops 1 cycle after the last response.
- MAX_OUTSTANDING=4, out[1] delays r_valid by 10 cycles, 6 requests -> exactly 4 grants, then gnt=0 until the first response. On that response cycle the 5th grant occurs with cnt held at 4.
- 2 requests outstanding on port 0, sel_i switched to 1 -> out[1].req stays 0 and in.gnt stays 0 until both port-0 responses return; the first port-1 grant arrives the cycle after cnt reaches 0; responses are routed from port 0 then port 1.
- Spurious out[1].r_valid while lock_sel=0 and cnt=2 -> err_o=1 from the next cycle; in.r_valid unaffected; cnt stays 2.
- rst_ni pulsed low with cnt=3 -> cnt=0, busy_o=0 and err_o=0 asynchronously; a subsequent stale r_valid on port 0 sets err_o=1.
- clear_i asserted in the same cycle as a grant with cnt=1 -> cnt=0 and err_o=0 next cycle; busy_o=0.
